wb_arbiter: RTL and testbench

//   Multi-source writeback unit: merges results from NUM_CH producers (ALU, MEM, PC+4, long-latency units)

---
 rtl/wb_arbiter.sv | 178 +++++++++++++++++
 tb/tb_wb_arbiter.sv | 202 ++++++++++++++++++++
 2 files changed

// File: rtl/wb_arbiter.sv
// Writeback merge unit: per-channel FIFOs feed a round-robin arbiter that
// retires at most one result per cycle onto registered register-file write outputs.
module wb_arbiter #(
  parameter  int WIDTH  = 32,
  parameter  int NUM_CH = 4,
  parameter  int DEPTH  = 2,
  localparam int CH_W   = (NUM_CH > 1) ? $clog2(NUM_CH) : 1
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    flush,
  input  logic [NUM_CH-1:0]       src_valid,
  output logic [NUM_CH-1:0]       src_ready,
  input  logic [NUM_CH*WIDTH-1:0] src_data,
  input  logic [NUM_CH*5-1:0]     src_rd,
  input  logic [NUM_CH-1:0]       src_wr_en,
  output logic                    wb_valid,
  output logic                    wb_wr_en,
  output logic [4:0]              wb_rd,
  output logic [WIDTH-1:0]        wb_data,
  output logic [CH_W-1:0]         wb_ch,
  output logic                    busy
);

  localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CNT_W = $clog2(DEPTH + 1);

  logic [WIDTH-1:0] mem_data_q [NUM_CH][DEPTH];
  logic [4:0]       mem_rd_q   [NUM_CH][DEPTH];
  logic             mem_we_q   [NUM_CH][DEPTH];
  logic [PTR_W-1:0] wr_ptr_q   [NUM_CH];
  logic [PTR_W-1:0] rd_ptr_q   [NUM_CH];
  logic [CNT_W-1:0] cnt_q      [NUM_CH];

  logic [NUM_CH-1:0] nonempty_s;
  logic [NUM_CH-1:0] full_s;
  logic [NUM_CH-1:0] push_s;
  logic [NUM_CH-1:0] pop_s;
  logic              grant_vld_s;
  logic [CH_W-1:0]   grant_s;
  logic [WIDTH-1:0]  ent_data_s;
  logic [4:0]        ent_rd_s;
  logic              ent_we_s;

  logic [CH_W-1:0]   rr_ptr_q, rr_ptr_d;
  logic              wb_valid_q, wb_valid_d;
  logic              wb_wr_en_q, wb_wr_en_d;
  logic [4:0]        wb_rd_q, wb_rd_d;
  logic [WIDTH-1:0]  wb_data_q, wb_data_d;
  logic [CH_W-1:0]   wb_ch_q, wb_ch_d;

  // Channel index offs positions after base, wrapping at NUM_CH.
  function automatic logic [CH_W-1:0] rr_index(input logic [CH_W-1:0] base,
                                               input int unsigned offs);
    int unsigned sum;
    sum = 32'(base) + offs;
    return CH_W'(sum % 32'(NUM_CH));
  endfunction

  // Occupancy flags from registered counts.
  always_comb begin
    nonempty_s = '0;
    full_s     = '0;
    for (int i = 0; i < NUM_CH; i++) begin
      nonempty_s[i] = (cnt_q[i] != '0);
      full_s[i]     = (cnt_q[i] == CNT_W'(DEPTH));
    end
  end

  assign src_ready = ~full_s & {NUM_CH{~flush & rst_n}};
  assign push_s    = src_valid & src_ready;
  assign busy      = |nonempty_s;

  // Round-robin pick: scanning downward lets the closest candidate to rr_ptr win.
  always_comb begin
    grant_vld_s = 1'b0;
    grant_s     = '0;
    for (int k = NUM_CH - 1; k >= 0; k--) begin
      grant_vld_s = grant_vld_s | nonempty_s[rr_index(rr_ptr_q, k)];
      grant_s     = nonempty_s[rr_index(rr_ptr_q, k)] ? rr_index(rr_ptr_q, k) : grant_s;
    end
  end

  // Single pop strobe for the granted channel.
  always_comb begin
    pop_s          = '0;
    pop_s[grant_s] = grant_vld_s & ~flush;
  end

  assign ent_data_s = mem_data_q[grant_s][rd_ptr_q[grant_s]];
  assign ent_rd_s   = mem_rd_q[grant_s][rd_ptr_q[grant_s]];
  assign ent_we_s   = mem_we_q[grant_s][rd_ptr_q[grant_s]];

  // Per-channel FIFO storage, pointers and counts.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < NUM_CH; i++) begin
        wr_ptr_q[i] <= '0;
        rd_ptr_q[i] <= '0;
        cnt_q[i]    <= '0;
        for (int j = 0; j < DEPTH; j++) begin
          mem_data_q[i][j] <= '0;
          mem_rd_q[i][j]   <= 5'd0;
          mem_we_q[i][j]   <= 1'b0;
        end
      end
    end else if (flush) begin
      for (int i = 0; i < NUM_CH; i++) begin
        wr_ptr_q[i] <= '0;
        rd_ptr_q[i] <= '0;
        cnt_q[i]    <= '0;
      end
    end else begin
      for (int i = 0; i < NUM_CH; i++) begin
        if (push_s[i]) begin
          mem_data_q[i][wr_ptr_q[i]] <= src_data[i*WIDTH +: WIDTH];
          mem_rd_q[i][wr_ptr_q[i]]   <= src_rd[i*5 +: 5];
          mem_we_q[i][wr_ptr_q[i]]   <= src_wr_en[i];
          wr_ptr_q[i]                <= wr_ptr_q[i] + PTR_W'(1);
        end
        if (pop_s[i]) begin
          rd_ptr_q[i] <= rd_ptr_q[i] + PTR_W'(1);
        end
        case ({push_s[i], pop_s[i]})
          2'b10:   cnt_q[i] <= cnt_q[i] + CNT_W'(1);
          2'b01:   cnt_q[i] <= cnt_q[i] - CNT_W'(1);
          default: cnt_q[i] <= cnt_q[i];
        endcase
      end
    end
  end

  // Retire the granted entry; x0 and non-writing entries retire without a write.
  always_comb begin
    rr_ptr_d   = rr_ptr_q;
    wb_valid_d = 1'b0;
    wb_wr_en_d = 1'b0;
    wb_rd_d    = wb_rd_q;
    wb_data_d  = wb_data_q;
    wb_ch_d    = wb_ch_q;
    if (grant_vld_s && !flush) begin
      wb_valid_d = 1'b1;
      wb_wr_en_d = ent_we_s && (ent_rd_s != 5'd0);
      wb_rd_d    = ent_rd_s;
      wb_data_d  = ent_data_s;
      wb_ch_d    = grant_s;
      rr_ptr_d   = rr_index(grant_s, 1);
    end else begin
      rr_ptr_d   = rr_ptr_q;
    end
  end

  // Output and arbitration pointer registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rr_ptr_q   <= '0;
      wb_valid_q <= 1'b0;
      wb_wr_en_q <= 1'b0;
      wb_rd_q    <= 5'd0;
      wb_data_q  <= '0;
      wb_ch_q    <= '0;
    end else begin
      rr_ptr_q   <= rr_ptr_d;
      wb_valid_q <= wb_valid_d;
      wb_wr_en_q <= wb_wr_en_d;
      wb_rd_q    <= wb_rd_d;
      wb_data_q  <= wb_data_d;
      wb_ch_q    <= wb_ch_d;
    end
  end

  assign wb_valid = wb_valid_q;
  assign wb_wr_en = wb_wr_en_q;
  assign wb_rd    = wb_rd_q;
  assign wb_data  = wb_data_q;
  assign wb_ch    = wb_ch_q;

endmodule

// File: tb/tb_wb_arbiter.sv
// Scoreboard bench for wb_arbiter: per-channel expected queues plus a
// cycle model of the round-robin retire path, compared every cycle.
module tb_wb_arbiter;
  localparam int W = 32;
  localparam int N = 4;
  localparam int D = 2;

  logic           clk = 1'b0;
  logic           rst_n = 1'b0;
  logic           flush = 1'b0;
  logic [N-1:0]   src_valid = '0;
  logic [N-1:0]   src_ready;
  logic [N*W-1:0] src_data = '0;
  logic [N*5-1:0] src_rd = '0;
  logic [N-1:0]   src_wr_en = '0;
  logic           wb_valid, wb_wr_en, busy;
  logic [4:0]     wb_rd;
  logic [W-1:0]   wb_data;
  logic [1:0]     wb_ch;

  wb_arbiter #(.WIDTH(W), .NUM_CH(N), .DEPTH(D)) dut (
    .clk(clk), .rst_n(rst_n), .flush(flush),
    .src_valid(src_valid), .src_ready(src_ready), .src_data(src_data),
    .src_rd(src_rd), .src_wr_en(src_wr_en),
    .wb_valid(wb_valid), .wb_wr_en(wb_wr_en), .wb_rd(wb_rd),
    .wb_data(wb_data), .wb_ch(wb_ch), .busy(busy)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [31:0] data;
    logic [4:0]  rd;
    logic        wr_en;
  } ent_t;

  ent_t        mq[N][$];
  int          mrr = 0;
  logic        e_valid = 1'b0, e_wren = 1'b0;
  logic [4:0]  e_rd = 5'd0;
  logic [31:0] e_data = 32'd0;
  logic [1:0]  e_ch = 2'd0;
  logic [N-1:0] acc = '0;
  int          checks = 0;
  int          errors = 0;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic set_src(input int ch, input logic v, input logic [4:0] rd,
                         input logic [31:0] data, input logic we);
    src_valid[ch]       = v;
    src_rd[ch*5 +: 5]   = rd;
    src_data[ch*W +: W] = data;
    src_wr_en[ch]       = we;
  endtask

  task automatic model_reset();
    for (int i = 0; i < N; i++) mq[i].delete();
    mrr = 0; e_valid = 1'b0; e_wren = 1'b0; e_rd = 5'd0; e_data = 32'd0; e_ch = 2'd0;
  endtask

  // One clock: check ready/busy before the edge, advance model, check outputs after.
  task automatic tick();
    logic [N-1:0] rdy;
    logic         bsy;
    int           g;
    ent_t         e;
    @(negedge clk);
    bsy = 1'b0;
    for (int i = 0; i < N; i++) begin
      rdy[i] = (mq[i].size() < D) && !flush;
      bsy    = bsy | (mq[i].size() > 0);
    end
    check("src_ready", 64'(src_ready), 64'(rdy));
    check("busy", 64'(busy), 64'(bsy));
    @(posedge clk);
    acc = src_valid & rdy;
    if (flush) begin
      for (int i = 0; i < N; i++) mq[i].delete();
      e_valid = 1'b0; e_wren = 1'b0;
    end else begin
      g = -1;
      for (int k = 0; k < N; k++)
        if (g < 0 && mq[(mrr + k) % N].size() > 0) g = (mrr + k) % N;
      if (g >= 0) begin
        e = mq[g].pop_front();
        e_valid = 1'b1; e_data = e.data; e_rd = e.rd; e_ch = 2'(g);
        e_wren = e.wr_en && (e.rd != 5'd0);
        mrr = (g + 1) % N;
      end else begin
        e_valid = 1'b0; e_wren = 1'b0;
      end
      for (int i = 0; i < N; i++)
        if (acc[i]) mq[i].push_back('{data: src_data[i*W +: W], rd: src_rd[i*5 +: 5], wr_en: src_wr_en[i]});
    end
    #1;
    check("wb_valid", 64'(wb_valid), 64'(e_valid));
    check("wb_wr_en", 64'(wb_wr_en), 64'(e_wren));
    check("wb_rd", 64'(wb_rd), 64'(e_rd));
    check("wb_data", 64'(wb_data), 64'(e_data));
    check("wb_ch", 64'(wb_ch), 64'(e_ch));
  endtask

  task automatic idle(input int n);
    src_valid = '0;
    for (int c = 0; c < n; c++) tick();
  endtask

  initial begin
    int k, guard;
    logic [31:0] t3 [3];
    #2;
    check("rst_ready", 64'(src_ready), 64'(0));
    check("rst_valid", 64'(wb_valid), 64'(0));
    check("rst_busy", 64'(busy), 64'(0));
    check("rst_data", 64'(wb_data), 64'(0));
    #10 rst_n = 1'b1;
    @(posedge clk); #1;

    // Single push on ch0.
    set_src(0, 1'b1, 5'd5, 32'hDEAD_BEEF, 1'b1);
    tick();
    idle(1);
    check("t1_retire", 64'({wb_valid, wb_wr_en, wb_rd, wb_ch}), 64'({1'b1, 1'b1, 5'd5, 2'd0}));
    idle(2);

    // All channels together.
    for (int i = 0; i < N; i++) set_src(i, 1'b1, 5'(i + 10), 32'hA000_0000 + 32'(i), 1'b1);
    tick();
    idle(6);

    // Ch2 back-to-back, producer holds until accepted.
    t3[0] = 32'h1111_0000; t3[1] = 32'h2222_0000; t3[2] = 32'h3333_0000;
    k = 0; guard = 0;
    while (k < 3 && guard < 20) begin
      set_src(2, 1'b1, 5'(k + 1), t3[k], 1'b1);
      tick();
      if (acc[2]) k++;
      guard++;
    end
    check("t3_accepts", 64'(k), 64'(3));
    idle(5);

    // rd=0 retires without a write.
    set_src(1, 1'b1, 5'd0, 32'h0000_1234, 1'b1);
    tick();
    idle(1);
    check("t4_x0", 64'({wb_valid, wb_wr_en}), 64'({1'b1, 1'b0}));
    idle(2);

    // Fill ch1/ch3, then flush.
    for (int c = 0; c < 2; c++) begin
      set_src(1, 1'b1, 5'd7, 32'hB100 + 32'(c), 1'b1);
      set_src(3, 1'b1, 5'd9, 32'hB300 + 32'(c), 1'b0);
      tick();
    end
    set_src(1, 1'b1, 5'd8, 32'hB1FF, 1'b1);
    flush = 1'b1;
    tick();
    flush = 1'b0;
    idle(4);

    // Async reset mid-burst.
    for (int i = 0; i < N; i++) set_src(i, 1'b1, 5'(i + 20), 32'hC000_0000 + 32'(i), 1'b1);
    tick();
    tick();
    rst_n = 1'b0;
    #1;
    model_reset();
    check("rst_mid_out", 64'({wb_valid, wb_wr_en, wb_rd, wb_ch}), 64'(0));
    check("rst_mid_data", 64'(wb_data), 64'(0));
    check("rst_mid_rdy", 64'({src_ready, busy}), 64'(0));
    src_valid = '0;
    @(posedge clk); @(posedge clk); #3;
    rst_n = 1'b1;
    @(posedge clk); #1;
    set_src(3, 1'b1, 5'd17, 32'hFACE_0001, 1'b1);
    tick();
    idle(1);
    check("t6_data", 64'(wb_data), 64'(32'hFACE_0001));
    idle(2);

    // Random traffic with occasional flushes.
    for (int c = 0; c < 400; c++) begin
      for (int i = 0; i < N; i++)
        set_src(i, 1'($urandom_range(0, 1)), 5'($urandom_range(0, 31)), $urandom, 1'($urandom_range(0, 1)));
      flush = ($urandom_range(0, 24) == 0);
      tick();
    end
    flush = 1'b0;
    idle(12);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
